// File: rtl/board_gpio_bank.sv
// -----------------------------------------------------------------------------
// board_gpio_bank
//
// General-purpose I/O bank placed at board top level in place of hard-wired
// LED / button / PIO pins. Each of the WIDTH channels has a direction bit, an
// output register, a two-flop input synchroniser, a per-channel debouncer,
// a selectable rising/falling edge detector and a sticky interrupt flag.
// The pads themselves are external tristate buffers driven by pio_o/pio_oe.
//
// Register map (word address on xaddr):
//   0 DATA     read: debounced input vector   write: OUT register
//   1 DIR      read/write, 1 = channel drives the pad
//   2 IRQ_EN   read/write, per-channel interrupt enable
//   3 IRQ_STAT read: sticky edge flags          write: 1 clears the flag
//   4 EDGE     read/write, 0 = rising edge, 1 = falling edge
//   5..7       reserved: read 0, writes ignored, still acknowledged
// Bits [31:WIDTH] of every register read 0 and ignore writes.
//
// Ports:
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset
//   xreq    in   bus request, held by the master until xack
//   xwr     in   1 = write, 0 = read
//   xaddr   in   word address
//   xdatai  in   write data
//   xdatao  out  read data, valid while xack = 1 (0 otherwise)
//   xack    out  single-cycle acknowledge
//   pio_i   in   raw pad inputs (asynchronous to clk)
//   pio_o   out  pad output values (OUT register)
//   pio_oe  out  pad output enables (DIR register)
//   irq     out  registered level interrupt
// -----------------------------------------------------------------------------
module board_gpio_bank #(
    parameter int               WIDTH      = 8,
    parameter int               DEB_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_OUT  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_DIR  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             xreq,
    input  logic             xwr,
    input  logic [2:0]       xaddr,
    input  logic [31:0]      xdatai,
    output logic [31:0]      xdatao,
    output logic             xack,
    input  logic [WIDTH-1:0] pio_i,
    output logic [WIDTH-1:0] pio_o,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_IEN  = 3'd2;
    localparam logic [2:0] ADDR_STAT = 3'd3;
    localparam logic [2:0] ADDR_EDGE = 3'd4;

    // Zero-extend a channel vector to the 32-bit bus width.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r          = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic             xack_r;
    logic [31:0]      xdatao_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] irq_en_r;
    logic [WIDTH-1:0] irq_stat_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] deb_q_r;
    logic             irq_r;

    logic             commit_s;
    logic             wr_s;
    logic             rd_s;
    logic [31:0]      rd_data_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] edge_s;

    // An access commits on the edge that raises xack; the cycle with xack high
    // blocks a second commit, so every access takes exactly two cycles.
    assign commit_s = xreq & ~xack_r;
    assign wr_s     = commit_s & xwr;
    assign rd_s     = commit_s & ~xwr;

    // Read-data multiplexer; reserved addresses return zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (xaddr)
            ADDR_DATA: rd_data_s = zext(deb_s);
            ADDR_DIR:  rd_data_s = zext(dir_r);
            ADDR_IEN:  rd_data_s = zext(irq_en_r);
            ADDR_STAT: rd_data_s = zext(irq_stat_r);
            ADDR_EDGE: rd_data_s = zext(edge_r);
            default:   rd_data_s = 32'd0;
        endcase
    end

    // Write-one-to-clear mask for the status register.
    always_comb begin
        w1c_s = {WIDTH{1'b0}};
        if (wr_s && (xaddr == ADDR_STAT)) begin
            w1c_s = xdatai[WIDTH-1:0];
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
    end

    // Per-channel edge detect against the previous debounced value.
    always_comb begin
        edge_s = (edge_r & deb_q_r & ~deb_s) | (~edge_r & ~deb_q_r & deb_s);
    end

    // Bus acknowledge and read-data capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xack_r   <= 1'b0;
            xdatao_r <= 32'd0;
        end else begin
            xack_r   <= commit_s;
            xdatao_r <= rd_s ? rd_data_s : 32'd0;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_r    <= RESET_OUT;
            dir_r    <= RESET_DIR;
            irq_en_r <= {WIDTH{1'b0}};
            edge_r   <= {WIDTH{1'b0}};
        end else if (wr_s) begin
            case (xaddr)
                ADDR_DATA: out_r    <= xdatai[WIDTH-1:0];
                ADDR_DIR:  dir_r    <= xdatai[WIDTH-1:0];
                ADDR_IEN:  irq_en_r <= xdatai[WIDTH-1:0];
                ADDR_EDGE: edge_r   <= xdatai[WIDTH-1:0];
                default: begin
                end
            endcase
        end
    end

    // Two-flop synchroniser and one-cycle delayed debounced value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_r    <= {WIDTH{1'b0}};
            s2_r    <= {WIDTH{1'b0}};
            deb_q_r <= {WIDTH{1'b0}};
        end else begin
            s1_r    <= pio_i;
            s2_r    <= s1_r;
            deb_q_r <= deb_s;
        end
    end

    // Sticky flags: a new edge wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_stat_r <= {WIDTH{1'b0}};
        end else begin
            irq_stat_r <= edge_s | (irq_stat_r & ~w1c_s);
        end
    end

    // Registered interrupt output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(irq_stat_r & irq_en_r);
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_deb_bypass
            assign deb_s = s2_r;
        end else begin : g_deb
            localparam int             CW      = $clog2(DEB_CYCLES + 1);
            localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

            logic [CW-1:0]    cnt_r [WIDTH];
            logic [WIDTH-1:0] deb_r;

            // Accept a new level only after it has differed for DEB_CYCLES
            // consecutive cycles; any return to the old level restarts the count.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    deb_r <= {WIDTH{1'b0}};
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_r[i] <= CW'(0);
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (s2_r[i] == deb_r[i]) begin
                            cnt_r[i] <= CW'(0);
                        end else if (cnt_r[i] == CNT_MAX) begin
                            deb_r[i] <= s2_r[i];
                            cnt_r[i] <= CW'(0);
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CW'(1);
                        end
                    end
                end
            end

            assign deb_s = deb_r;
        end
    endgenerate

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_xdatai_s;
            assign unused_xdatai_s = ^xdatai[31:WIDTH];
        end
    endgenerate

    assign xack   = xack_r;
    assign xdatao = xdatao_r;
    assign pio_o  = out_r;
    assign pio_oe = dir_r;
    assign irq    = irq_r;

endmodule

// File: tb/tb_board_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_board_gpio_bank
//
// Directed bench for board_gpio_bank (WIDTH=8, DEB_CYCLES=16). A table of bus
// accesses with hand-computed results covers the register map; hand-written
// sequences cover debounce timing, interrupt timing, falling-edge mode,
// clear/set collision and reset during an access. All driving and sampling
// happens 1 time unit after a rising clock edge.
// -----------------------------------------------------------------------------
module tb_board_gpio_bank;

    logic        clk;
    logic        resetn;
    logic        xreq;
    logic        xwr;
    logic [2:0]  xaddr;
    logic [31:0] xdatai;
    logic [31:0] xdatao;
    logic        xack;
    logic [7:0]  pio_i;
    logic [7:0]  pio_o;
    logic [7:0]  pio_oe;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    board_gpio_bank #(
        .WIDTH      (8),
        .DEB_CYCLES (16),
        .RESET_OUT  (8'h00),
        .RESET_DIR  (8'h00)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .xreq   (xreq),
        .xwr    (xwr),
        .xaddr  (xaddr),
        .xdatai (xdatai),
        .xdatao (xdatao),
        .xack   (xack),
        .pio_i  (pio_i),
        .pio_o  (pio_o),
        .pio_oe (pio_oe),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_o;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; checks xack is high for exactly one cycle.
    task automatic bus(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata);
        xreq   = 1'b1;
        xwr    = wr;
        xaddr  = addr;
        xdatai = wdata;
        tick(1);
        check("xack_high", {31'd0, xack}, 32'd1);
        rdata  = xdatao;
        xreq   = 1'b0;
        xwr    = 1'b0;
        xdatai = 32'd0;
        tick(1);
        check("xack_low", {31'd0, xack}, 32'd0);
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        bus(1'b1, addr, wdata, d);
    endtask

    task automatic rd_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, addr, 32'd0, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 3'd1, 32'h0000_00F0, 32'h0, 8'h00, 8'hF0};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_00A5, 32'h0, 8'hA5, 8'hF0};
        vecs[2]  = '{1'b0, 3'd1, 32'h0,         32'h0000_00F0, 8'hA5, 8'hF0};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,         32'h0, 8'hA5, 8'hF0};
        vecs[4]  = '{1'b0, 3'd6, 32'h0,         32'h0, 8'hA5, 8'hF0};
        vecs[5]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0, 8'hA5, 8'hF0};
        vecs[6]  = '{1'b0, 3'd5, 32'h0,         32'h0, 8'hA5, 8'hF0};
        vecs[7]  = '{1'b1, 3'd2, 32'hFFFF_FF03, 32'h0, 8'hA5, 8'hF0};
        vecs[8]  = '{1'b0, 3'd2, 32'h0,         32'h0000_0003, 8'hA5, 8'hF0};
        vecs[9]  = '{1'b1, 3'd4, 32'h0000_01FE, 32'h0, 8'hA5, 8'hF0};
        vecs[10] = '{1'b0, 3'd4, 32'h0,         32'h0000_00FE, 8'hA5, 8'hF0};
        vecs[11] = '{1'b1, 3'd4, 32'h0,         32'h0, 8'hA5, 8'hF0};
        vecs[12] = '{1'b1, 3'd2, 32'h0,         32'h0, 8'hA5, 8'hF0};
        vecs[13] = '{1'b0, 3'd3, 32'h0,         32'h0, 8'hA5, 8'hF0};
        vecs[14] = '{1'b1, 3'd0, 32'hFFFF_FF3C, 32'h0, 8'h3C, 8'hF0};
        vecs[15] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0, 8'h3C, 8'hFF};
        vecs[16] = '{1'b0, 3'd1, 32'h0,         32'h0000_00FF, 8'h3C, 8'hFF};
        vecs[17] = '{1'b0, 3'd0, 32'h0,         32'h0, 8'h3C, 8'hFF};
        vecs[18] = '{1'b0, 3'd7, 32'h0,         32'h0, 8'h3C, 8'hFF};

        resetn = 1'b0;
        xreq   = 1'b0;
        xwr    = 1'b0;
        xaddr  = 3'd0;
        xdatai = 32'd0;
        pio_i  = 8'h00;

        // Reset state
        tick(2);
        check("rst_pio_o",  {24'd0, pio_o},  32'h0);
        check("rst_pio_oe", {24'd0, pio_oe}, 32'h0);
        check("rst_irq",    {31'd0, irq},    32'h0);
        check("rst_xack",   {31'd0, xack},   32'h0);
        check("rst_xdatao", xdatao,          32'h0);
        resetn = 1'b1;
        tick(1);
        rd_check("rst_data", 3'd0, 32'h0);

        // Register map table
        for (int i = 0; i < 19; i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_pio_o", i),  {24'd0, pio_o},  {24'd0, vecs[i].exp_o});
            check($sformatf("vec%0d_pio_oe", i), {24'd0, pio_oe}, {24'd0, vecs[i].exp_oe});
        end

        // Debounce: a 15-cycle pulse is rejected
        pio_i = 8'h01;
        tick(15);
        pio_i = 8'h00;
        tick(10);
        rd_check("glitch_data", 3'd0, 32'h0);
        rd_check("glitch_stat", 3'd3, 32'h0);

        // Debounce: held level accepted 18 cycles after the pin change
        pio_i = 8'h01;
        tick(17);
        rd_check("deb_data_early", 3'd0, 32'h0);
        rd_check("deb_data_late",  3'd0, 32'h1);
        rd_check("deb_stat_set",   3'd3, 32'h1);
        check("deb_irq_disabled", {31'd0, irq}, 32'h0);
        wr_reg(3'd3, 32'h1);
        rd_check("deb_stat_clr", 3'd3, 32'h0);

        // Falling ch0 in rising mode raises no flag
        pio_i = 8'h00;
        tick(25);
        rd_check("fall_data", 3'd0, 32'h0);
        rd_check("fall_stat", 3'd3, 32'h0);

        // Interrupt timing: flag at edge 19, irq at edge 20
        wr_reg(3'd2, 32'h1);
        pio_i = 8'h01;
        tick(19);
        check("irq_before", {31'd0, irq}, 32'h0);
        tick(1);
        check("irq_after", {31'd0, irq}, 32'h1);
        rd_check("irq_stat", 3'd3, 32'h1);
        wr_reg(3'd3, 32'h1);
        check("irq_w1c", {31'd0, irq}, 32'h0);
        rd_check("irq_stat_clr", 3'd3, 32'h0);

        // Falling mode on ch1 (and ch0, which is steady high: no spurious flag)
        wr_reg(3'd4, 32'h3);
        pio_i = 8'h03;
        tick(25);
        rd_check("fedge_rise_stat", 3'd3, 32'h0);
        pio_i = 8'h01;
        tick(25);
        rd_check("fedge_fall_stat", 3'd3, 32'h2);
        rd_check("fedge_data", 3'd0, 32'h1);
        check("fedge_irq_masked", {31'd0, irq}, 32'h0);

        // Clear in the same cycle as a new edge: the flag survives
        wr_reg(3'd4, 32'h0);
        pio_i = 8'h03;
        tick(18);
        wr_reg(3'd3, 32'h2);
        rd_check("w1c_vs_edge", 3'd3, 32'h2);
        wr_reg(3'd3, 32'h2);
        rd_check("w1c_plain", 3'd3, 32'h0);

        // Reset asserted during a pending write
        pio_i  = 8'h00;
        xreq   = 1'b1;
        xwr    = 1'b1;
        xaddr  = 3'd1;
        xdatai = 32'h55;
        #2;
        resetn = 1'b0;
        #1;
        check("rstw_xack",   {31'd0, xack},   32'h0);
        check("rstw_pio_oe", {24'd0, pio_oe}, 32'h0);
        tick(1);
        check("rstw_pio_oe2", {24'd0, pio_oe}, 32'h0);
        check("rstw_pio_o",   {24'd0, pio_o},  32'h0);
        check("rstw_irq",     {31'd0, irq},    32'h0);
        xreq   = 1'b0;
        xwr    = 1'b0;
        xdatai = 32'd0;
        resetn = 1'b1;
        tick(1);
        rd_check("rstw_dir", 3'd1, 32'h0);

        // Reset asserted while xack is high drops it at once
        xreq  = 1'b1;
        xwr   = 1'b0;
        xaddr = 3'd1;
        tick(1);
        check("rstr_xack_pre", {31'd0, xack}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstr_xack",   {31'd0, xack}, 32'h0);
        check("rstr_xdatao", xdatao,        32'h0);
        xreq = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(1);
        rd_check("rstr_ien", 3'd2, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
